// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer for the 5-stage core: load-use bubbles, redirect squash,
// memory-wait freeze with timeout, debug halt drain and stall/flush counters.
module pipe_hazard_ctrl #(
    parameter int MEM_TIMEOUT  = 64,
    parameter int DRAIN_CYCLES = 4,
    parameter int CW           = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [4:0]    id_rs1,
    input  logic [4:0]    id_rs2,
    input  logic          id_use_rs1,
    input  logic          id_use_rs2,
    input  logic          ex_mr,
    input  logic [4:0]    ex_rd,
    input  logic          ex_redirect,
    input  logic          mem_req,
    input  logic          mem_ack,
    input  logic          halt_req,
    input  logic          cnt_clr,
    output logic          pc_en,
    output logic          ifid_en,
    output logic          idex_en,
    output logic          exmem_en,
    output logic          pc_redirect,
    output logic          ifid_flush,
    output logic          idex_flush,
    output logic          memwb_flush,
    output logic          halt_ack,
    output logic          mem_err,
    output logic [1:0]    state,
    output logic [CW-1:0] stall_cnt,
    output logic [CW-1:0] flush_cnt
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        DRAIN    = 2'd2,
        HALTED   = 2'd3
    } state_t;

    localparam int WW = $clog2(MEM_TIMEOUT + 1);
    localparam int DW = $clog2(DRAIN_CYCLES + 1);
    localparam logic [WW-1:0] WAIT_MAX  = WW'(MEM_TIMEOUT);
    localparam logic [DW-1:0] DRAIN_MAX = DW'(DRAIN_CYCLES);

    function automatic logic src_hit(input logic use_f, input logic [4:0] rs,
                                     input logic [4:0] rd);
        return use_f && (rs == rd);
    endfunction

    state_t        st_q, st_d;
    logic [WW-1:0] wait_q, wait_d;
    logic [DW-1:0] drain_q, drain_d;
    logic          ld_use, mwait;
    logic          pc_en_c, ifid_en_c, idex_en_c, exmem_en_c;
    logic          redir_c, ifid_fl_c, idex_fl_c, memwb_fl_c, err_c;

    assign ld_use = ex_mr && (ex_rd != 5'd0) &&
                    (src_hit(id_use_rs1, id_rs1, ex_rd) || src_hit(id_use_rs2, id_rs2, ex_rd));
    assign mwait  = mem_req && !mem_ack;

    always_comb begin
        pc_en_c    = 1'b1;
        ifid_en_c  = 1'b1;
        idex_en_c  = 1'b1;
        exmem_en_c = 1'b1;
        redir_c    = 1'b0;
        ifid_fl_c  = 1'b0;
        idex_fl_c  = 1'b0;
        memwb_fl_c = 1'b0;
        err_c      = 1'b0;
        st_d       = st_q;
        wait_d     = wait_q;
        drain_d    = drain_q;
        case (st_q)
            RUN: begin
                if (mwait) begin
                    {pc_en_c, ifid_en_c, idex_en_c, exmem_en_c} = 4'b0000;
                    memwb_fl_c = 1'b1;
                    st_d       = MEM_WAIT;
                    wait_d     = WW'(1);
                end else if (ex_redirect) begin
                    redir_c   = 1'b1;
                    ifid_fl_c = 1'b1;
                    idex_fl_c = 1'b1;
                end else if (ld_use) begin
                    pc_en_c   = 1'b0;
                    ifid_en_c = 1'b0;
                    idex_fl_c = 1'b1;
                end else if (halt_req) begin
                    pc_en_c   = 1'b0;
                    ifid_fl_c = 1'b1;
                    st_d      = DRAIN;
                    drain_d   = DW'(1);
                end
            end
            MEM_WAIT: begin
                if (!mem_ack) begin
                    if (wait_q < WAIT_MAX) begin
                        {pc_en_c, ifid_en_c, idex_en_c, exmem_en_c} = 4'b0000;
                        memwb_fl_c = 1'b1;
                        wait_d     = wait_q + 1'b1;
                    end else begin
                        // Timed-out op is squashed at MEM/WB so it never writes back.
                        err_c      = 1'b1;
                        memwb_fl_c = 1'b1;
                        st_d       = RUN;
                        wait_d     = '0;
                    end
                end else begin
                    st_d   = RUN;
                    wait_d = '0;
                    if (ex_redirect) begin
                        redir_c   = 1'b1;
                        ifid_fl_c = 1'b1;
                        idex_fl_c = 1'b1;
                    end else if (ld_use) begin
                        pc_en_c   = 1'b0;
                        ifid_en_c = 1'b0;
                        idex_fl_c = 1'b1;
                    end
                end
            end
            DRAIN: begin
                pc_en_c   = 1'b0;
                ifid_fl_c = 1'b1;
                if (mwait) begin
                    {pc_en_c, ifid_en_c, idex_en_c, exmem_en_c} = 4'b0000;
                    ifid_fl_c  = 1'b0;
                    memwb_fl_c = 1'b1;
                end else if (ex_redirect) begin
                    pc_en_c   = 1'b1;
                    redir_c   = 1'b1;
                    idex_fl_c = 1'b1;
                    drain_d   = drain_q + 1'b1;
                    if (drain_q == DRAIN_MAX) begin
                        st_d    = HALTED;
                        drain_d = '0;
                    end
                end else if (ld_use) begin
                    ifid_en_c = 1'b0;
                    idex_fl_c = 1'b1;
                end else begin
                    drain_d = drain_q + 1'b1;
                    if (drain_q == DRAIN_MAX) begin
                        st_d    = HALTED;
                        drain_d = '0;
                    end
                end
            end
            HALTED: begin
                {pc_en_c, ifid_en_c, idex_en_c, exmem_en_c} = 4'b0000;
                if (!halt_req) st_d = RUN;
            end
            default: st_d = RUN;
        endcase
    end

    // While reset is held the pipe is frozen with bubbles loaded.
    assign pc_en       = rst && pc_en_c;
    assign ifid_en     = rst && ifid_en_c;
    assign idex_en     = rst && idex_en_c;
    assign exmem_en    = rst && exmem_en_c;
    assign pc_redirect = rst && redir_c;
    assign ifid_flush  = !rst || ifid_fl_c;
    assign idex_flush  = !rst || idex_fl_c;
    assign memwb_flush = !rst || memwb_fl_c;
    assign halt_ack    = rst && (st_q == HALTED);
    assign mem_err     = rst && err_c;
    assign state       = st_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            st_q      <= RUN;
            wait_q    <= '0;
            drain_q   <= '0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            st_q    <= st_d;
            wait_q  <= wait_d;
            drain_q <= drain_d;
            if (cnt_clr) begin
                stall_cnt <= '0;
                flush_cnt <= '0;
            end else begin
                if (!pc_en_c && (st_q != HALTED)) stall_cnt <= stall_cnt + 1'b1;
                if (redir_c) flush_cnt <= flush_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl with directed per-cycle vectors.
module tb_pipe_hazard_ctrl;

    localparam logic [9:0] ADV     = 10'b1111000000;
    localparam logic [9:0] FRZ     = 10'b0000000100;
    localparam logic [9:0] RED     = 10'b1111111000;
    localparam logic [9:0] LDU     = 10'b0011001000;
    localparam logic [9:0] HREQ    = 10'b0111010000;
    localparam logic [9:0] DRN     = 10'b0111010000;
    localparam logic [9:0] DRN_LDU = 10'b0011011000;
    localparam logic [9:0] HALT    = 10'b0000000010;
    localparam logic [9:0] TMO     = 10'b1111000101;
    localparam logic [9:0] RSTV    = 10'b0000011100;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic       id_use_rs1, id_use_rs2, ex_mr, ex_redirect;
    logic       mem_req, mem_ack, halt_req, cnt_clr;
    logic       pc_en, ifid_en, idex_en, exmem_en, pc_redirect;
    logic       ifid_flush, idex_flush, memwb_flush, halt_ack, mem_err;
    logic [1:0] state;
    logic [3:0] stall_cnt, flush_cnt;
    logic [9:0] ctrl_vec;

    typedef struct packed {
        logic [15:0] id;
        logic [9:0]  ctrl;
        logic [1:0]  st;
        logic [3:0]  sc;
        logic [3:0]  fc;
    } exp_t;

    exp_t       sb[$];
    int         n_chk = 0;
    int         n_err = 0;
    int         n_push = 0;
    int         n_pop = 0;
    logic [3:0] m_stall = 4'd0;
    logic [3:0] m_flush = 4'd0;

    pipe_hazard_ctrl #(.MEM_TIMEOUT(4), .DRAIN_CYCLES(4), .CW(4)) dut (
        .clk(clk), .rst(rst),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .ex_mr(ex_mr), .ex_rd(ex_rd), .ex_redirect(ex_redirect),
        .mem_req(mem_req), .mem_ack(mem_ack), .halt_req(halt_req), .cnt_clr(cnt_clr),
        .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en),
        .pc_redirect(pc_redirect), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
        .memwb_flush(memwb_flush), .halt_ack(halt_ack), .mem_err(mem_err),
        .state(state), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    assign ctrl_vec = {pc_en, ifid_en, idex_en, exmem_en, pc_redirect,
                       ifid_flush, idex_flush, memwb_flush, halt_ack, mem_err};

    // Monitor: one expected entry per cycle, checked mid-cycle.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            n_pop++;
            n_chk++;
            if (ctrl_vec !== e.ctrl) begin
                n_err++;
                $display("FAIL vec%0d ctrl: got %b want %b", e.id, ctrl_vec, e.ctrl);
            end
            n_chk++;
            if (state !== e.st) begin
                n_err++;
                $display("FAIL vec%0d state: got %0d want %0d", e.id, state, e.st);
            end
            n_chk++;
            if (stall_cnt !== e.sc) begin
                n_err++;
                $display("FAIL vec%0d stall_cnt: got %0d want %0d", e.id, stall_cnt, e.sc);
            end
            n_chk++;
            if (flush_cnt !== e.fc) begin
                n_err++;
                $display("FAIL vec%0d flush_cnt: got %0d want %0d", e.id, flush_cnt, e.fc);
            end
        end
    end

    // Queue the expected response for the inputs currently applied, then
    // advance the counter model using the hand-written control vector.
    task automatic cyc(input logic [9:0] ec, input logic [1:0] es);
        exp_t e;
        e.id   = 16'(n_push);
        e.ctrl = ec;
        e.st   = es;
        e.sc   = m_stall;
        e.fc   = m_flush;
        sb.push_back(e);
        n_push++;
        if (!rst || cnt_clr) begin
            m_stall = 4'd0;
            m_flush = 4'd0;
        end else begin
            if (!ec[9] && es != 2'd3) m_stall = m_stall + 4'd1;
            if (ec[5]) m_flush = m_flush + 4'd1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_lduse(input logic on);
        ex_mr      = on;
        ex_rd      = 5'd5;
        id_rs1     = 5'd3;
        id_use_rs1 = 1'b1;
        id_rs2     = 5'd5;
        id_use_rs2 = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b0;
        id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
        id_use_rs1 = 1'b0; id_use_rs2 = 1'b0; ex_mr = 1'b0; ex_redirect = 1'b0;
        mem_req = 1'b0; mem_ack = 1'b0; halt_req = 1'b0; cnt_clr = 1'b0;
        @(posedge clk);
        #1;
        cyc(RSTV, 2'd0);
        rst = 1'b1;
        cyc(ADV, 2'd0);

        // Load-use on rs2, then non-hazard variants.
        set_lduse(1'b1);
        cyc(LDU, 2'd0);
        set_lduse(1'b0);
        cyc(ADV, 2'd0);
        ex_mr = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0; id_use_rs1 = 1'b1; id_use_rs2 = 1'b0;
        cyc(ADV, 2'd0);
        ex_rd = 5'd7; id_rs1 = 5'd7; id_use_rs1 = 1'b0;
        cyc(ADV, 2'd0);
        id_use_rs1 = 1'b1;
        cyc(LDU, 2'd0);
        ex_mr = 1'b0;

        // Redirect in RUN.
        ex_redirect = 1'b1;
        cyc(RED, 2'd0);
        ex_redirect = 1'b0;
        cyc(ADV, 2'd0);

        // Memory wait released with load-use, then with redirect.
        mem_req = 1'b1; mem_ack = 1'b0;
        cyc(FRZ, 2'd0);
        cyc(FRZ, 2'd1);
        cyc(FRZ, 2'd1);
        mem_ack = 1'b1;
        set_lduse(1'b1);
        cyc(LDU, 2'd1);
        set_lduse(1'b0);
        mem_req = 1'b0; mem_ack = 1'b0;
        cyc(ADV, 2'd0);
        mem_req = 1'b1;
        cyc(FRZ, 2'd0);
        mem_ack = 1'b1; ex_redirect = 1'b1;
        cyc(RED, 2'd1);
        mem_req = 1'b0; mem_ack = 1'b0; ex_redirect = 1'b0;
        cyc(ADV, 2'd0);

        // Timeout on the 4th MEM_WAIT cycle.
        mem_req = 1'b1;
        cyc(FRZ, 2'd0);
        cyc(FRZ, 2'd1);
        cyc(FRZ, 2'd1);
        cyc(FRZ, 2'd1);
        cyc(TMO, 2'd1);
        mem_req = 1'b0;
        cyc(ADV, 2'd0);

        // Clean halt.
        halt_req = 1'b1;
        cyc(HREQ, 2'd0);
        for (int i = 0; i < 4; i++) cyc(DRN, 2'd2);
        cyc(HALT, 2'd3);
        cyc(HALT, 2'd3);
        halt_req = 1'b0;
        cyc(HALT, 2'd3);
        cyc(ADV, 2'd0);

        // Halt with load-use and redirect inside the drain; halt_req dropped early.
        halt_req = 1'b1;
        cyc(HREQ, 2'd0);
        halt_req = 1'b0;
        cyc(DRN, 2'd2);
        set_lduse(1'b1);
        cyc(DRN_LDU, 2'd2);
        set_lduse(1'b0);
        cyc(DRN, 2'd2);
        ex_redirect = 1'b1;
        cyc(RED, 2'd2);
        ex_redirect = 1'b0;
        cyc(DRN, 2'd2);
        cyc(HALT, 2'd3);
        cyc(ADV, 2'd0);

        // Clear beats a simultaneous redirect; then 16 redirects wrap the counter.
        cnt_clr = 1'b1; ex_redirect = 1'b1;
        cyc(RED, 2'd0);
        cnt_clr = 1'b0;
        for (int i = 0; i < 16; i++) cyc(RED, 2'd0);
        ex_redirect = 1'b0;
        cyc(ADV, 2'd0);
        set_lduse(1'b1);
        cyc(LDU, 2'd0);
        set_lduse(1'b0);
        cyc(ADV, 2'd0);

        // Reset during MEM_WAIT, then during DRAIN.
        mem_req = 1'b1;
        cyc(FRZ, 2'd0);
        cyc(FRZ, 2'd1);
        rst = 1'b0;
        cyc(RSTV, 2'd1);
        mem_req = 1'b0;
        cyc(RSTV, 2'd0);
        rst = 1'b1;
        cyc(ADV, 2'd0);
        halt_req = 1'b1;
        cyc(HREQ, 2'd0);
        cyc(DRN, 2'd2);
        rst = 1'b0; halt_req = 1'b0;
        cyc(RSTV, 2'd2);
        cyc(RSTV, 2'd0);
        rst = 1'b1;
        cyc(ADV, 2'd0);

        repeat (3) @(posedge clk);
        n_chk++;
        if (n_pop != n_push || sb.size() != 0) begin
            n_err++;
            $display("FAIL drain_sb: got %0d popped want %0d", n_pop, n_push);
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
